// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory controller.
// Holds the FSM state encoding, RV32I load/store funct3 codes and decode helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DATA,
        ST_WR,
        ST_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
               ((f3 == F3_W) && (off != 2'b00));
    endfunction

    // Clears the offset bits that would make a half/word access straddle a word.
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        if ((f3 == F3_H) || (f3 == F3_HU))
            return {off[1], 1'b0};
        if (f3 == F3_W)
            return 2'b00;
        return off;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request, response and memory-port signals of the LSU memory controller.
// master = core/memory side, slave = controller.
interface lsu_mem_ctrl_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wen, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wen, mem_wdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane datapath: load lane extract with sign/zero extension, and store merge
// of a byte/half into the word read back from memory.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word[{offset, 3'b000} +: 8];
    assign half_v = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'h0, byte_v};
            F3_HU:   load_data = {16'h0, half_v};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_word = word;
        case (funct3)
            F3_B: store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (offset[1])
                    store_word[31:16] = wdata[15:0];
                else
                    store_word[15:0] = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer onto a word-wide memory without byte enables (SB/SH via RMW).
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return an error
// instead of having their low address bits forced to zero.
//   state   | meaning
//   IDLE    | waiting for a request, req_ready=1
//   RD      | word address presented for read
//   DATA    | read data back: extract load lane or merge store data
//   WR      | single-cycle word write
//   RESP    | response held until resp_ready
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic           clk,
    input logic           rst,
    lsu_mem_ctrl_if.slave bus
);

    lsu_state_e        state_q, state_d;
    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] req_addr_eff;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wword_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err      = !is_legal_f3(bus.req_we, bus.req_funct3) ||
                          is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign req_addr_eff = bus.req_addr;
`else
    assign req_err      = !is_legal_f3(bus.req_we, bus.req_funct3);
    assign req_addr_eff = {bus.req_addr[ADDR_W-1:2], align_off(bus.req_funct3, bus.req_addr[1:0])};
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = ST_RESP;
                    else if (bus.req_we && (bus.req_funct3 == F3_W))
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_DATA;
            ST_DATA: state_d = we_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    lsu_lane u_lane (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .word       (bus.mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= req_addr_eff;
                wdata_q <= bus.req_wdata;
                wword_q <= bus.req_wdata;
                rdata_q <= '0;
                err_q   <= req_err;
            end
            if (state_q == ST_DATA) begin
                if (we_q)
                    wword_q <= store_word;
                else
                    rdata_q <= load_data;
            end
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    // Gated by rst so a reset landing in WR drops the write at that very edge.
    assign bus.mem_wen    = (state_q == ST_WR) && !rst;
    assign bus.mem_wdata  = wword_q;

endmodule
